// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic bit-stream generator: FSM encoding,
// LFSR feedback taps, default seed and the LFSR step function.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sc_state_e;

  // Taps for x^16+x^14+x^13+x^11+1 in a right-shifting Fibonacci LFSR:
  // feedback is bits 0,2,3,5 and enters at bit 15.
  localparam logic [15:0] LFSR_TAPS       = 16'h002D;
  localparam logic [15:0] SC_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR with synchronous load and step enable.
module lfsr16
  import sc_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = SC_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        enable,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Load wins over enable; the caller guarantees a nonzero seed.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (enable) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/stochastic_gen.sv
// Stochastic bit-stream generator: emits `window` bits, each 1 when the LFSR
// state is <= the latched value, and counts the emitted ones.
module stochastic_gen
  import sc_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = SC_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic [31:0]      window,
  input  logic [WIDTH-1:0] seed,
  output logic             stochastic_bit,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      ones_count,
  output logic [1:0]       state_dbg
);

  sc_state_e        state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [31:0]      window_q, window_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      ones_q, ones_d;
  logic             bit_q, bit_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             lfsr_load;
  logic             lfsr_en;
  logic [15:0]      lfsr_state;
  logic [WIDTH-1:0] seed_eff;
  logic             first_bit;
  logic             next_bit;

  lfsr16 #(
    .RESET_SEED(DEFAULT_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed_eff),
    .enable(lfsr_en),
    .state (lfsr_state)
  );

  // The output bit is a flop, so it is computed one edge ahead: from the seed
  // at start, otherwise from the LFSR state the step is about to produce.
  assign seed_eff  = (seed == '0) ? DEFAULT_SEED : seed;
  assign first_bit = (seed_eff <= value);
  assign next_bit  = (lfsr_next(lfsr_state) <= value_q);

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    window_d  = window_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    bit_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          value_d   = value;
          window_d  = window;
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          ones_d    = '0;
          cnt_d     = '0;
          if (window == 32'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            bit_d   = first_bit;
            cnt_d   = 32'd1;
            ones_d  = {31'd0, first_bit};
          end
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        // cnt_q is the number of bits already emitted; it never exceeds window_q.
        if (cnt_q == window_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          lfsr_en = 1'b1;
          valid_d = 1'b1;
          bit_d   = next_bit;
          cnt_d   = cnt_q + 32'd1;
          ones_d  = ones_q + {31'd0, next_bit};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      value_q  <= '0;
      window_q <= '0;
      cnt_q    <= '0;
      ones_q   <= '0;
      bit_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      window_q <= window_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
      bit_q    <= bit_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign stochastic_bit = bit_q;
  assign bit_valid      = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign ones_count     = ones_q;
  assign state_dbg      = state_q;

endmodule
